// File: rtl/simplerisc_pkg.sv
// rtl/simplerisc_pkg.sv - SimpleRISC opcodes, ALU codes, immediate modifiers, ctrl bit indices
// and the combinational control decode.
package simplerisc_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_MUL  = 5'b00010, OP_DIV = 5'b00011,
    OP_MOD  = 5'b00100, OP_CMP  = 5'b00101, OP_AND  = 5'b00110, OP_OR  = 5'b00111,
    OP_NOT  = 5'b01000, OP_MOV  = 5'b01001, OP_LSL  = 5'b01010, OP_LSR = 5'b01011,
    OP_ASR  = 5'b01100, OP_NOP  = 5'b01101, OP_LD   = 5'b01110, OP_ST  = 5'b01111,
    OP_BEQ  = 5'b10000, OP_BGT  = 5'b10001, OP_B    = 5'b10010, OP_CALL = 5'b10011,
    OP_RET  = 5'b10100
  } opcode_e;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_NONE = 5'd31;

  localparam logic [1:0] IMM_SEXT = 2'b00;
  localparam logic [1:0] IMM_ZEXT = 2'b01;
  localparam logic [1:0] IMM_HIGH = 2'b10;

  localparam int CTRL_CALL = 0;
  localparam int CTRL_LD   = 1;
  localparam int CTRL_UBR  = 2;
  localparam int CTRL_BGT  = 3;
  localparam int CTRL_BEQ  = 4;
  localparam int CTRL_IMM  = 5;
  localparam int CTRL_WB   = 6;
  localparam int CTRL_ST   = 7;
  localparam int CTRL_RET  = 8;

  localparam int RA_DEFAULT = 15;

  typedef struct packed {
    logic [8:0] ctrl;
    logic [4:0] alu;
    logic       uses_b;
  } dec_t;

  // Bit 26 is part of the branch offset for branch formats, so isImm only applies to ALU/ld/st.
  function automatic dec_t decode_ctrl(input opcode_e op, input logic i_bit);
    dec_t d;
    logic alu_op;
    logic mem_op;
    alu_op = (op <= OP_ASR);
    mem_op = (op == OP_LD) || (op == OP_ST);
    d.ctrl = '0;
    d.ctrl[CTRL_CALL] = (op == OP_CALL);
    d.ctrl[CTRL_LD]   = (op == OP_LD);
    d.ctrl[CTRL_UBR]  = (op == OP_B) || (op == OP_CALL) || (op == OP_RET);
    d.ctrl[CTRL_BGT]  = (op == OP_BGT);
    d.ctrl[CTRL_BEQ]  = (op == OP_BEQ);
    d.ctrl[CTRL_IMM]  = i_bit && (alu_op || mem_op);
    d.ctrl[CTRL_WB]   = (alu_op && (op != OP_CMP)) || (op == OP_LD) || (op == OP_CALL);
    d.ctrl[CTRL_ST]   = (op == OP_ST);
    d.ctrl[CTRL_RET]  = (op == OP_RET);
    d.alu    = alu_op ? op : (mem_op ? ALU_ADD : ALU_NONE);
    d.uses_b = (op == OP_ST) || (alu_op && !i_bit);
    return d;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 2R1W register file with write-through bypass; contents are not reset.
module decode_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 16,
  localparam int RAW  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [RAW-1:0]  waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RAW-1:0]  raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [RAW-1:0]  raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (we) regs_q[waddr] <= wdata;
  end

  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs_q[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs_q[raddr_b];

endmodule

// File: rtl/decode_stage_hz.sv
// rtl/decode_stage_hz.sv - SimpleRISC decode stage: D->E register, handshake, flush, load-use interlock.
// DECODE_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module decode_stage_hz
  import simplerisc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 16,
  parameter int RA_IDX = RA_DEFAULT,
  localparam int RAW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [RAW-1:0]  wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] branch_target_e,
  output logic [XLEN-1:0] op_a_e,
  output logic [XLEN-1:0] op_b_e,
  output logic [XLEN-1:0] op2_e,
  output logic [31:0]     instr_e,
  output logic [8:0]      ctrl_e,
  output logic [4:0]      alu_e,
  output logic [RAW-1:0]  rs1_e,
  output logic [RAW-1:0]  rs2_e,
  output logic [RAW-1:0]  rd_e
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  opcode_e         opcode;
  dec_t            dec;
  logic [RAW-1:0]  f_rd, f_rs1, f_rs2, addr_a, addr_b;
  logic [XLEN-1:0] rdata_a, rdata_b, immx, br_target;
  logic            advance, hazard, xfer;

  logic            out_valid_d, out_valid_q;
  logic [XLEN-1:0] pc_d, pc_q, bt_d, bt_q, op_a_d, op_a_q, op_b_d, op_b_q, op2_d, op2_q;
  logic [31:0]     instr_d, instr_q;
  logic [8:0]      ctrl_d, ctrl_q;
  logic [4:0]      alu_d, alu_q;
  logic [RAW-1:0]  rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;

  always_comb begin
    opcode = opcode_e'(instr_in[31:27]);
    dec    = decode_ctrl(opcode, instr_in[26]);
    f_rd   = RAW'(instr_in[25:22]);
    f_rs1  = RAW'(instr_in[21:18]);
    f_rs2  = RAW'(instr_in[17:14]);
    addr_a = dec.ctrl[CTRL_RET] ? RAW'(RA_IDX) : f_rs1;
    addr_b = dec.ctrl[CTRL_ST] ? f_rd : f_rs2;
    case (instr_in[17:16])
      IMM_ZEXT: immx = XLEN'(instr_in[15:0]);
      IMM_HIGH: immx = XLEN'({instr_in[15:0], 16'h0000});
      default:  immx = XLEN'($signed(instr_in[15:0]));
    endcase
    br_target = pc_in + XLEN'($signed({instr_in[26:0], 2'b00}));
  end

  decode_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (addr_a),
    .rdata_a (rdata_a),
    .raddr_b (addr_b),
    .rdata_b (rdata_b)
  );

  // A load in E whose destination feeds this instruction forces one bubble.
  assign hazard   = out_valid_q && ctrl_q[CTRL_LD] && (opcode != OP_NOP) &&
                    ((addr_a == rd_q) || (dec.uses_b && (addr_b == rd_q)));
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance && !hazard && !flush;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    pc_d    = pc_q;    bt_d    = bt_q;    op_a_d = op_a_q; op_b_d = op_b_q;
    op2_d   = op2_q;   instr_d = instr_q; ctrl_d = ctrl_q; alu_d  = alu_q;
    rs1_d   = rs1_q;   rs2_d   = rs2_q;   rd_d   = rd_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (advance) begin
      out_valid_d = xfer;
      if (xfer) begin
        pc_d    = pc_in;
        bt_d    = br_target;
        op_a_d  = rdata_a;
        op_b_d  = dec.ctrl[CTRL_IMM] ? immx : rdata_b;
        op2_d   = rdata_b;
        instr_d = instr_in;
        ctrl_d  = dec.ctrl;
        alu_d   = dec.alu;
        rs1_d   = f_rs1;
        rs2_d   = f_rs2;
        rd_d    = f_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      pc_q    <= '0; bt_q    <= '0; op_a_q <= '0; op_b_q <= '0;
      op2_q   <= '0; instr_q <= '0; ctrl_q <= '0; alu_q  <= '0;
      rs1_q   <= '0; rs2_q   <= '0; rd_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pc_q    <= pc_d;    bt_q    <= bt_d;    op_a_q <= op_a_d; op_b_q <= op_b_d;
      op2_q   <= op2_d;   instr_q <= instr_d; ctrl_q <= ctrl_d; alu_q  <= alu_d;
      rs1_q   <= rs1_d;   rs2_q   <= rs2_d;   rd_q   <= rd_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign pc_e            = pc_q;
  assign branch_target_e = bt_q;
  assign op_a_e          = op_a_q;
  assign op_b_e          = op_b_q;
  assign op2_e           = op2_q;
  assign instr_e         = instr_q;
  assign ctrl_e          = ctrl_q;
  assign alu_e           = alu_q;
  assign rs1_e           = rs1_q;
  assign rs2_e           = rs2_q;
  assign rd_e            = rd_q;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (((in_valid && hazard) && (stall_cnt_q != '1)) ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + ((flush && (flush_cnt_q != '1)) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage_hz.sv
// tb/tb_decode_stage_hz.sv - directed scoreboard bench for decode_stage_hz
module tb_decode_stage_hz;

    localparam logic [4:0] B_ADD = 5'b00000, B_SUB = 5'b00001, B_NOP = 5'b01101, B_LD = 5'b01110;
    localparam logic [4:0] B_ST  = 5'b01111, B_B   = 5'b10010, B_RET = 5'b10100;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, wb_en = 1'b0, out_valid, out_ready = 1'b1;
    logic [31:0] pc_in = '0, instr_in = '0, wb_data = '0;
    logic [3:0]  wb_addr = '0;
    logic [31:0] pc_e, branch_target_e, op_a_e, op_b_e, op2_e, instr_e;
    logic [8:0]  ctrl_e;
    logic [4:0]  alu_e;
    logic [3:0]  rs1_e, rs2_e, rd_e;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    decode_stage_hz dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in),
        .instr_in(instr_in), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .pc_e(pc_e), .branch_target_e(branch_target_e),
        .op_a_e(op_a_e), .op_b_e(op_b_e), .op2_e(op2_e), .instr_e(instr_e), .ctrl_e(ctrl_e),
        .alu_e(alu_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
`ifdef DECODE_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, bt, a, b, op2, instr;
        logic [8:0]  ctrl;
        logic [4:0]  alu;
        logic [3:0]  rd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rf [16];
    int          n_chk = 0, n_fail = 0, n_flush_exp = 0, n_stall_exp = 0;
    logic        rdy_seen, ov_seen;
    logic        test_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic i, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [17:0] low);
        return {op, i, rd, rs1, low};
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input logic we,
                                   input logic [3:0] wa, input logic [31:0] wd);
        exp_t e;
        logic [3:0]  aa, ab;
        logic [31:0] immx, rb;
        case (ins[31:27])
            B_ADD:   begin e.ctrl = {3'b001, ins[26], 5'b00000}; e.alu = 5'd0;  end
            B_SUB:   begin e.ctrl = {3'b001, ins[26], 5'b00000}; e.alu = 5'd1;  end
            B_LD:    begin e.ctrl = {3'b001, ins[26], 5'b00010}; e.alu = 5'd0;  end
            B_ST:    begin e.ctrl = {3'b010, ins[26], 5'b00000}; e.alu = 5'd0;  end
            B_B:     begin e.ctrl = 9'b000000100;                e.alu = 5'd31; end
            B_RET:   begin e.ctrl = 9'b100000100;                e.alu = 5'd31; end
            default: begin e.ctrl = 9'b000000000;                e.alu = 5'd31; end
        endcase
        aa = (ins[31:27] == B_RET) ? 4'd15 : ins[21:18];
        ab = (ins[31:27] == B_ST) ? ins[25:22] : ins[17:14];
        case (ins[17:16])
            2'b01:   immx = {16'h0000, ins[15:0]};
            2'b10:   immx = {ins[15:0], 16'h0000};
            default: immx = {{16{ins[15]}}, ins[15:0]};
        endcase
        rb      = (we && wa == ab) ? wd : rf[ab];
        e.a     = (we && wa == aa) ? wd : rf[aa];
        e.b     = e.ctrl[5] ? immx : rb;
        e.op2   = rb;
        e.pc    = pc;
        e.bt    = pc + {{3{ins[26]}}, ins[26:0], 2'b00};
        e.instr = ins;
        e.rd    = ins[25:22];
        return e;
    endfunction

    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic we,
                        input logic [3:0] wa, input logic [31:0] wd);
        exp_t e;
        in_valid = iv; instr_in = ins; pc_in = pc; out_ready = ordy; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        rdy_seen = in_ready;
        ov_seen  = out_valid;
        if (out_valid) begin
            chk("sb_unexpected_output", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb[0];
                chk("pc_e", pc_e, e.pc);
                chk("branch_target_e", branch_target_e, e.bt);
                chk("op_a_e", op_a_e, e.a);
                chk("op_b_e", op_b_e, e.b);
                chk("op2_e", op2_e, e.op2);
                chk("instr_e", instr_e, e.instr);
                chk("ctrl_e", 32'(ctrl_e), 32'(e.ctrl));
                chk("alu_e", 32'(alu_e), 32'(e.alu));
                chk("rd_e", 32'(rd_e), 32'(e.rd));
                if (ordy || fl) void'(sb.pop_front());
            end
        end
        if (iv && in_ready) sb.push_back(model(ins, pc, we, wa, wd));
        if (fl) n_flush_exp++;
        if (we) rf[wa] = wd;
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        step(1'b1, ins, pc, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        #200000;
        if (!test_done) begin
            n_fail++;
            $error("FAIL watchdog: test did not complete in time");
            $finish;
        end
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_ctrl_e", 32'(ctrl_e), 32'd0);
        chk("reset_alu_e", 32'(alu_e), 32'd0);
        chk("reset_op_a_e", op_a_e, 32'd0);
        chk("reset_rd_e", 32'(rd_e), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'(i), 32'h0100_0000 + 32'(i) * 32'h0101);

        issue(enc(B_ADD, 1'b1, 4'd1, 4'd2, {2'b00, 16'hFFFC}), 32'h40);
        chk("imm_sext_op_b", op_b_e, 32'hFFFF_FFFC);
        chk("imm_sext_isImm", 32'(ctrl_e[5]), 32'd1);
        issue(enc(B_ADD, 1'b1, 4'd1, 4'd2, {2'b10, 16'h1234}), 32'h44);
        chk("imm_high_op_b", op_b_e, 32'h1234_0000);
        issue({B_B, 27'h7FF_FFFF}, 32'h100);
        chk("branch_target", branch_target_e, 32'h0000_00FC);
        step(1'b1, enc(B_ADD, 1'b0, 4'd4, 4'd2, {4'd3, 14'd0}), 32'h104, 1'b1, 1'b0, 1'b1, 4'd2, 32'hDEAD);
        chk("bypass_op_a", op_a_e, 32'h0000_DEAD);
        issue(enc(B_RET, 1'b0, 4'd0, 4'd0, 18'd0), 32'h200);
        chk("ret_op_a", op_a_e, rf[15]);

        issue(enc(B_SUB, 1'b0, 4'd6, 4'd7, {4'd8, 14'd0}), 32'h300);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_pc_e", pc_e, 32'd0);
        chk("midreset_ctrl_e", 32'(ctrl_e), 32'd0);
        sb.delete();
        n_flush_exp = 0;
        n_stall_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(enc(B_ADD, 1'b0, 4'd9, 4'd10, {4'd11, 14'd0}), 32'h400);
        chk("latency_out_valid", 32'(out_valid), 32'd1);

        issue(enc(B_LD, 1'b1, 4'd3, 4'd4, 18'd0), 32'h500);
        issue(enc(B_ADD, 1'b0, 4'd5, 4'd3, {4'd6, 14'd0}), 32'h504);
        chk("loaduse_in_ready", 32'(rdy_seen), 32'd0);
        n_stall_exp++;
        issue(enc(B_ADD, 1'b0, 4'd5, 4'd3, {4'd6, 14'd0}), 32'h504);
        chk("loaduse_bubble", 32'(ov_seen), 32'd0);
        chk("loaduse_resume", 32'(rdy_seen), 32'd1);
        issue(enc(B_LD, 1'b1, 4'd3, 4'd4, 18'd0), 32'h508);
        issue(enc(B_NOP, 1'b0, 4'd0, 4'd3, 18'd0), 32'h50C);
        chk("nop_no_hazard", 32'(rdy_seen), 32'd1);
        issue(enc(B_LD, 1'b1, 4'd3, 4'd4, 18'd0), 32'h510);
        issue(enc(B_SUB, 1'b0, 4'd8, 4'd7, {4'd7, 14'd0}), 32'h514);
        chk("indep_no_stall", 32'(rdy_seen), 32'd1);

        issue(enc(B_ST, 1'b1, 4'd9, 4'd10, {2'b00, 16'h0008}), 32'h600);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, enc(B_ADD, 1'b0, 4'd1, 4'd1, {4'd1, 14'd0}), 32'h604, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
            chk("backpressure_in_ready", 32'(rdy_seen), 32'd0);
        end
        issue(enc(B_ADD, 1'b0, 4'd1, 4'd1, {4'd1, 14'd0}), 32'h604);
        chk("backpressure_release", 32'(rdy_seen), 32'd1);

        step(1'b1, enc(B_SUB, 1'b0, 4'd2, 4'd3, {4'd4, 14'd0}), 32'h700, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
        chk("flush_in_ready", 32'(rdy_seen), 32'd0);
        idle();
        chk("flush_out_valid", 32'(ov_seen), 32'd0);
        idle();
        chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef DECODE_PERF_CNT_EN
        chk("flush_cnt", flush_cnt, 32'(n_flush_exp));
        chk("stall_cnt", stall_cnt, 32'(n_stall_exp));
`endif
        test_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
Parametrised SimpleRISC decode stage with a D→E pipeline register, valid/ready handshake, flush, and load-use interlock.
- Decodes one instruction per cycle.
- Reads operands from an internal register file with write-through bypass from the RW stage.
- Generates the immediate, branch target and control bundle.
- Sits between fetch and execute and replaces the fixed-width, always-advancing decode register.

Parameters:
- XLEN, 32: datapath width (pc, operands, immediate).
- NREGS, 16: architectural register count, power of 2; RAW = log2(NREGS).
- RA_IDX, 15: return-address register index used by call/ret.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts it this cycle.
- pc_in  in  XLEN  pc of the fetched instruction.
- instr_in  in  32  instruction word.
- flush  in  1  branch taken in EX; kill the D and E slots.
- wb_en  in  1  RW writeback enable.
- wb_addr  in  RAW  writeback register.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  E slot holds a live instruction.
- out_ready  in  1  execute consumes the E slot.
- pc_e, branch_target_e, op_a_e, op_b_e, op2_e  out  XLEN each  registered decode results.
- instr_e  out  32  registered instruction word.
- ctrl_e  out  9  {isRet, isSt, isWb, isImm, isBeq, isBgt, isUbranch, isLd, isCall}.
- alu_e  out  5  ALU operation.
- rs1_e, rs2_e, rd_e  out  RAW each  register indices, for forwarding.

Behaviour:
Field decoding
- opcode = instr[31:27], I = instr[26], rd = [25:22], rs1 = [21:18], rs2 = [17:14].
- Read port A = RA_IDX when ret, else rs1.
- Read port B = rd when st, else rs2.

Immediate and branch target
- immx from instr[17:0], modifier [17:16]:
  - 00: sign-extend.
  - 01: zero-extend.
  - 10: imm[15:0] << 16.
  - 11: treated as 00.
- branch_target = pc_in + (sext(instr[26:0]) << 2), modulo 2^XLEN.

Operand selection
- op_b = immx when isImm, else read port B.
- op2 = read port B.

Register file
- Synchronous write on clk when wb_en.
- Combinational read with bypass: if wb_en && wb_addr == read addr, return wb_data.
- Contents are not reset.

Handshake
- E slot advances when !out_valid || out_ready.
- in_ready = advance && !hazard.
- Transfer occurs when in_valid && in_ready.

Load-use hazard
- hazard = out_valid && ctrl_e.isLd && (addrA == rd_e || (uses B && addrB == rd_e)) for the incoming instruction.
- On hazard with advance: load a bubble (out_valid = 0) and hold the fetch side, giving a 1-cycle stall.
- A nop never hazards.

Pipeline register update (advance && !flush)
- Without a transfer: out_valid <= 0; data fields hold.

Flush
- Highest priority: out_valid <= 0 and in_ready = 0 that cycle.
- A simultaneous wb still writes the register file.

Stall
- out_valid && !out_ready: all E outputs hold and in_ready = 0.

Reset
- All outputs are 0, including out_valid, ctrl_e, alu_e and the indices.
- Reset asserted mid-stall drops the held instruction.

Latency
- 1 cycle from accepted instruction to out_valid.

Optional Feature:
DECODE_PERF_CNT_EN
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt counts cycles with in_valid && hazard.
  - flush_cnt counts flush cycles.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package simplerisc_pkg:
  - Opcode constants (add=00000 … ret=10100, ld=01110, st=01111, nop=01101).
  - ALU code constants.
  - Imm modifier constants.
  - ctrl bit index constants.
  - RA default.
- Sub-module decode_regfile:
  - Parameters XLEN, NREGS.
  - Two read ports, one write port, with bypass.
- Control decode is a combinational function in the package.

Test Plan:
- Reset: rst_n=0 mid-stream → all outputs 0 and out_valid=0; release, then 1 cycle after the first accepted instruction out_valid=1.
- Immediate: add r1,r2,#-4 (mod 00) → op_b_e=32'hFFFFFFFC, isImm=1. Mod 10 with imm 16'h1234 → op_b_e=32'h12340000.
- Branch: pc_in=32'h100, offset 27'h7FFFFFF → branch_target_e=32'hFC.
- Load-use: ld r3,[r4] followed by add r5,r3,r6 → one bubble (out_valid=0) and in_ready=0 for 1 cycle, then add issues. A sub using only r7 after the ld → no stall.
- Bypass: wb_en=1, wb_addr=2, wb_data=32'hDEAD in the same cycle as decoding a read of r2 → op_a_e=32'hDEAD. ret → op_a_e = r15 contents.
- Flush and backpressure:
  - out_ready=0 for 3 cycles → E outputs stable and in_ready=0.
  - flush together with in_valid → out_valid=0 next cycle, instruction dropped.
  - With DECODE_PERF_CNT_EN, flush_cnt increments by 1.
